// File: rtl/sata_cmd_master.sv
// sata_cmd_master
//   Host-side initiator for the SATA controller's three-stream interface.
//   Accepts one read/write request, sends the opcode/address/length command
//   packet, then passes write data from a local source or read data to a
//   local sink. Beat counts are checked against tlast, reads run an
//   inactivity watchdog, and each request ends with a done pulse plus err_code.
//
// Ports
//   clk, rst              clock, synchronous active-low reset
//   sata_link_up          controller link status
//   req_*                 request handshake (wr, sector addr, length in words)
//   wsrc_*                local write data source
//   rsink_*               local read data sink
//   command_m_axi_*       command stream out (3 words per request)
//   write_m_axi_*         write data stream out
//   read_s_axi_*          read data stream in
//   busy, done, err_code  status (0 ok, 1 zero len, 2 short, 3 long,
//                         4 timeout, 5 link lost)
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for a request, req_ready follows link
// CMD_OP   | sending opcode word
// CMD_ADDR | sending sector address word
// CMD_LEN  | sending length word with tlast
// WDATA    | passing write beats source -> write stream
// RDATA    | passing read beats read stream -> sink
// RDRAIN   | discarding excess read beats up to tlast
// DONE     | one-cycle done pulse, err_code valid

module sata_cmd_master #(
    parameter logic [31:0] CMD_WR  = 32'h0000_0001,
    parameter logic [31:0] CMD_RD  = 32'h0000_0002,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sata_link_up,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_len,

    input  logic        wsrc_valid,
    output logic        wsrc_ready,
    input  logic [31:0] wsrc_data,

    output logic        rsink_valid,
    input  logic        rsink_ready,
    output logic [31:0] rsink_data,
    output logic        rsink_last,

    output logic        command_m_axi_tvalid,
    output logic        command_m_axi_tlast,
    input  logic        command_m_axi_tready,
    output logic [31:0] command_m_axi_tdata,

    output logic        write_m_axi_tvalid,
    output logic        write_m_axi_tlast,
    input  logic        write_m_axi_tready,
    output logic [31:0] write_m_axi_tdata,

    input  logic        read_s_axi_tvalid,
    input  logic        read_s_axi_tlast,
    output logic        read_s_axi_tready,
    input  logic [31:0] read_s_axi_tdata,

    output logic        busy,
    output logic        done,
    output logic [2:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD_OP   = 3'd1,
        CMD_ADDR = 3'd2,
        CMD_LEN  = 3'd3,
        WDATA    = 3'd4,
        RDATA    = 3'd5,
        RDRAIN   = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] wdog_q, wdog_d;
    logic [2:0]  err_q, err_d;

    logic [15:0] last_idx;
    logic        is_last_beat;

    assign last_idx     = len_q - 16'd1;
    assign is_last_beat = (cnt_q == last_idx);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wdog_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wdog_d  = '0;
        err_d   = err_q;

        req_ready            = 1'b0;
        wsrc_ready           = 1'b0;
        rsink_valid          = 1'b0;
        rsink_data           = '0;
        rsink_last           = 1'b0;
        command_m_axi_tvalid = 1'b0;
        command_m_axi_tlast  = 1'b0;
        command_m_axi_tdata  = '0;
        write_m_axi_tvalid   = 1'b0;
        write_m_axi_tlast    = 1'b0;
        write_m_axi_tdata    = '0;
        read_s_axi_tready    = 1'b0;
        busy                 = (state_q != IDLE);
        done                 = (state_q == DONE);
        err_code             = err_q;

        case (state_q)
            IDLE: begin
                // rst gating keeps req_ready low while reset is held
                req_ready = sata_link_up & rst;
                if (req_valid && req_ready) begin
                    wr_d   = req_wr;
                    addr_d = req_addr;
                    len_d  = req_len;
                    cnt_d  = '0;
                    if (req_len == 16'd0) begin
                        err_d   = 3'd1;
                        state_d = DONE;
                    end else begin
                        err_d   = 3'd0;
                        state_d = CMD_OP;
                    end
                end
            end
            CMD_OP: begin
                command_m_axi_tvalid = 1'b1;
                command_m_axi_tdata  = wr_q ? CMD_WR : CMD_RD;
                if (command_m_axi_tready) state_d = CMD_ADDR;
            end
            CMD_ADDR: begin
                command_m_axi_tvalid = 1'b1;
                command_m_axi_tdata  = addr_q;
                if (command_m_axi_tready) state_d = CMD_LEN;
            end
            CMD_LEN: begin
                command_m_axi_tvalid = 1'b1;
                command_m_axi_tlast  = 1'b1;
                command_m_axi_tdata  = {16'h0, len_q};
                if (command_m_axi_tready) state_d = wr_q ? WDATA : RDATA;
            end
            WDATA: begin
                write_m_axi_tvalid = wsrc_valid;
                wsrc_ready         = write_m_axi_tready;
                write_m_axi_tdata  = wsrc_data;
                write_m_axi_tlast  = is_last_beat;
                if (wsrc_valid && write_m_axi_tready) begin
                    cnt_d = cnt_q + 16'd1;
                    if (is_last_beat) state_d = DONE;
                end
            end
            RDATA: begin
                rsink_valid       = read_s_axi_tvalid;
                rsink_data        = read_s_axi_tdata;
                rsink_last        = read_s_axi_tlast;
                read_s_axi_tready = rsink_ready;
                if (read_s_axi_tvalid && rsink_ready) begin
                    cnt_d = cnt_q + 16'd1;
                    if (read_s_axi_tlast) begin
                        if (!is_last_beat) err_d = 3'd2;
                        state_d = DONE;
                    end else if (is_last_beat) begin
                        err_d   = 3'd3;
                        state_d = RDRAIN;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 3'd4;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            RDRAIN: begin
                read_s_axi_tready = 1'b1;
                if (read_s_axi_tvalid) begin
                    if (read_s_axi_tlast) state_d = DONE;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 3'd4;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Link loss overrides whatever the active state decided this cycle.
        if ((state_q != IDLE) && (state_q != DONE) && !sata_link_up) begin
            err_d   = 3'd5;
            state_d = DONE;
        end
    end

endmodule

// File: tb/tb_sata_cmd_master.sv
// tb_sata_cmd_master
//   Directed bench for sata_cmd_master with TIMEOUT = 16. Inputs change
//   1ns after the rising edge; outputs are checked on the falling edge.

module tb_sata_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        sata_link_up;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr;
    logic [15:0] req_len;
    logic        wsrc_valid, wsrc_ready;
    logic [31:0] wsrc_data;
    logic        rsink_valid, rsink_ready, rsink_last;
    logic [31:0] rsink_data;
    logic        cmd_tvalid, cmd_tlast, cmd_tready;
    logic [31:0] cmd_tdata;
    logic        wr_tvalid, wr_tlast, wr_tready;
    logic [31:0] wr_tdata;
    logic        rd_tvalid, rd_tlast, rd_tready;
    logic [31:0] rd_tdata;
    logic        busy, done;
    logic [2:0]  err_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sata_cmd_master #(
        .CMD_WR (32'h0000_0001),
        .CMD_RD (32'h0000_0002),
        .TIMEOUT(16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .sata_link_up        (sata_link_up),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_wr              (req_wr),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .wsrc_valid          (wsrc_valid),
        .wsrc_ready          (wsrc_ready),
        .wsrc_data           (wsrc_data),
        .rsink_valid         (rsink_valid),
        .rsink_ready         (rsink_ready),
        .rsink_data          (rsink_data),
        .rsink_last          (rsink_last),
        .command_m_axi_tvalid(cmd_tvalid),
        .command_m_axi_tlast (cmd_tlast),
        .command_m_axi_tready(cmd_tready),
        .command_m_axi_tdata (cmd_tdata),
        .write_m_axi_tvalid  (wr_tvalid),
        .write_m_axi_tlast   (wr_tlast),
        .write_m_axi_tready  (wr_tready),
        .write_m_axi_tdata   (wr_tdata),
        .read_s_axi_tvalid   (rd_tvalid),
        .read_s_axi_tlast    (rd_tlast),
        .read_s_axi_tready   (rd_tready),
        .read_s_axi_tdata    (rd_tdata),
        .busy                (busy),
        .done                (done),
        .err_code            (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [15:0] len);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        chk("req_ready", req_ready, 1);
        tick;
        req_valid = 1'b0;
    endtask

    task automatic cmd_phase(input logic [31:0] op, input logic [31:0] addr, input logic [15:0] len);
        logic [31:0] words [3];
        words[0] = op;
        words[1] = addr;
        words[2] = {16'h0, len};
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk("cmd_tvalid", cmd_tvalid, 1);
            chk("cmd_tdata", cmd_tdata, words[w]);
            chk("cmd_tlast", cmd_tlast, (w == 2) ? 1 : 0);
            tick;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int j;
        rst = 1'b0; sata_link_up = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = '0; req_len = 16'd1;
        wsrc_valid = 1'b0; wsrc_data = '0; rsink_ready = 1'b1;
        cmd_tready = 1'b1; wr_tready = 1'b1;
        rd_tvalid = 1'b0; rd_tlast = 1'b0; rd_tdata = '0;

        // reset values, with link up and a request pending
        tick; tick;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_code, 0);
        chk("rst_cmd_tvalid", cmd_tvalid, 0);
        chk("rst_cmd_tdata", cmd_tdata, 0);
        chk("rst_wr_tvalid", wr_tvalid, 0);
        chk("rst_rd_tready", rd_tready, 0);
        chk("rst_rsink_valid", rsink_valid, 0);
        tick;
        rst = 1'b1; req_valid = 1'b0;
        tick;

        // write, addr 0x1000, len 4, all readies high
        send_req(1'b1, 32'h0000_1000, 16'd4);
        cmd_phase(32'h1, 32'h1000, 16'd4);
        for (int i = 0; i < 4; i++) begin
            wsrc_valid = 1'b1;
            wsrc_data  = 32'hA0 + i;
            @(negedge clk);
            chk("wr_tvalid", wr_tvalid, 1);
            chk("wr_tdata", wr_tdata, 32'hA0 + i);
            chk("wr_tlast", wr_tlast, (i == 3) ? 1 : 0);
            chk("wsrc_ready", wsrc_ready, 1);
            chk("wr_cmd_idle", cmd_tvalid, 0);
            tick;
        end
        wsrc_valid = 1'b0;
        @(negedge clk);
        chk("wr_done", done, 1);
        chk("wr_err", err_code, 0);
        tick;
        @(negedge clk);
        chk("wr_done_pulse", done, 0);
        chk("wr_idle_busy", busy, 0);

        // read, len 3, first command word stalled, rsink_ready toggling
        tick;
        send_req(1'b0, 32'h0000_0040, 16'd3);
        cmd_tready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk("stall_tvalid", cmd_tvalid, 1);
            chk("stall_tdata", cmd_tdata, 32'h2);
            tick;
        end
        cmd_tready = 1'b1;
        cmd_phase(32'h2, 32'h40, 16'd3);
        j = 0;
        for (int c = 0; c < 12 && j < 3; c++) begin
            rsink_ready = c[0];
            rd_tvalid   = 1'b1;
            rd_tdata    = 32'hB0 + j;
            rd_tlast    = (j == 2);
            @(negedge clk);
            chk("rd_rsink_valid", rsink_valid, 1);
            chk("rd_rsink_data", rsink_data, 32'hB0 + j);
            chk("rd_rsink_last", rsink_last, (j == 2) ? 1 : 0);
            chk("rd_tready", rd_tready, rsink_ready);
            tick;
            if (rsink_ready) j++;
        end
        rd_tvalid = 1'b0; rd_tlast = 1'b0; rsink_ready = 1'b1;
        chk("rd3_beats", j, 3);
        @(negedge clk);
        chk("rd3_done", done, 1);
        chk("rd3_err", err_code, 0);
        tick;

        // read, len 4, tlast on beat 2 -> short
        send_req(1'b0, 32'h0000_0080, 16'd4);
        cmd_phase(32'h2, 32'h80, 16'd4);
        for (int b = 0; b < 3; b++) begin
            rd_tvalid = 1'b1; rd_tdata = 32'hC0 + b; rd_tlast = (b == 2);
            @(negedge clk);
            chk("short_done_early", done, 0);
            tick;
        end
        rd_tvalid = 1'b0; rd_tlast = 1'b0;
        @(negedge clk);
        chk("short_done", done, 1);
        chk("short_err", err_code, 2);
        tick;

        // read, len 2, 5 beats -> long, 3 beats drained
        send_req(1'b0, 32'h0000_00C0, 16'd2);
        cmd_phase(32'h2, 32'hC0, 16'd2);
        for (int b = 0; b < 5; b++) begin
            rd_tvalid = 1'b1; rd_tdata = 32'hD0 + b; rd_tlast = (b == 4);
            rsink_ready = (b < 2);
            @(negedge clk);
            chk("long_rsink_valid", rsink_valid, (b < 2) ? 1 : 0);
            chk("long_rd_tready", rd_tready, 1);
            if (b == 2) chk("long_err_drain", err_code, 3);
            tick;
        end
        rd_tvalid = 1'b0; rd_tlast = 1'b0; rsink_ready = 1'b1;
        @(negedge clk);
        chk("long_done", done, 1);
        chk("long_err", err_code, 3);
        tick;

        // read with no beats -> timeout 16 cycles after entering RDATA
        send_req(1'b0, 32'h0000_0100, 16'd1);
        cmd_phase(32'h2, 32'h100, 16'd1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("to_wait_done", done, 0);
            chk("to_wait_err", err_code, 0);
            tick;
        end
        @(negedge clk);
        chk("to_done", done, 1);
        chk("to_err", err_code, 4);
        tick;

        // zero length -> done the cycle after accept, no command
        send_req(1'b0, 32'h0000_0200, 16'd0);
        @(negedge clk);
        chk("zl_cmd_tvalid", cmd_tvalid, 0);
        chk("zl_done", done, 1);
        chk("zl_err", err_code, 1);
        tick;
        @(negedge clk);
        chk("zl_done_pulse", done, 0);

        // link down in IDLE -> request not taken
        sata_link_up = 1'b0; req_valid = 1'b1; req_len = 16'd4;
        @(negedge clk);
        chk("nolink_req_ready", req_ready, 0);
        tick;
        @(negedge clk);
        chk("nolink_busy", busy, 0);
        req_valid = 1'b0; sata_link_up = 1'b1;
        tick;

        // link loss on write beat 2 of 8
        send_req(1'b1, 32'h0000_2000, 16'd8);
        cmd_phase(32'h1, 32'h2000, 16'd8);
        for (int i = 0; i < 2; i++) begin
            wsrc_valid = 1'b1; wsrc_data = 32'hE0 + i;
            tick;
        end
        sata_link_up = 1'b0; wsrc_data = 32'hE2;
        tick;
        @(negedge clk);
        chk("ll_wr_tvalid", wr_tvalid, 0);
        chk("ll_wsrc_ready", wsrc_ready, 0);
        chk("ll_done", done, 1);
        chk("ll_err", err_code, 5);
        wsrc_valid = 1'b0;
        tick;
        sata_link_up = 1'b1;
        @(negedge clk);
        chk("ll_err_hold", err_code, 5);
        chk("ll_idle", busy, 0);
        tick;

        // reset asserted mid-command
        send_req(1'b0, 32'h0000_3000, 16'd5);
        tick;
        rst = 1'b0;
        tick;
        @(negedge clk);
        chk("mr_cmd_tvalid", cmd_tvalid, 0);
        chk("mr_cmd_tdata", cmd_tdata, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_req_ready", req_ready, 0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            @(negedge clk);
            chk("mr_no_done", done, 0);
            chk("mr_err", err_code, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
